// File: rtl/sprite_drawer_pkg.sv
// Shared definitions for the sprite drawer: FSM encodings, screen limits,
// bus widths and the stage-1 pixel record carried down the output pipeline.
package sprite_drawer_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 10;
    localparam int COLOUR_W = 15;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic           valid;
        logic           inb;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } px_stage_t;

    // Sums carry one extra bit so an overflow past the screen edge clips instead of wrapping.
    function automatic logic in_bounds(input logic [X_W:0] x_sum, input logic [Y_W:0] y_sum);
        return (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Raster counter for the sprite memory: walks col/row in raster order and
// keeps the linear address in step, flagging the final word of the sprite.
module sprite_addr_gen
    import sprite_drawer_pkg::*;
#(
    parameter int SPRITE_W = 28,
    parameter int SPRITE_H = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_col,
    output logic [ADDR_W-1:0] o_row,
    output logic              o_last
);

    localparam int                N         = SPRITE_W * SPRITE_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] COL_MAX   = ADDR_W'(SPRITE_W - 1);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_clear) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_advance) begin
            r_addr <= r_addr + 1'b1;
            if (r_col == COL_MAX) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = (r_addr == LAST_ADDR);

endmodule

// File: rtl/sprite_drawer.sv
// Sprite blitter: fetches a SPRITE_W x SPRITE_H sprite and emits clipped pixel writes.
// Define SPRITE_TRANSPARENCY_EN to suppress plots of words whose bit 0 is clear.
module sprite_drawer
    import sprite_drawer_pkg::*;
#(
    parameter int SPRITE_W = 28,
    parameter int SPRITE_H = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [15:0]         rd_data,
    output logic                plot,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour,
    output logic                busy,
    output logic                done
);

    logic [1:0]          r_state;
    logic                r_drain_cnt;
    logic                r_done;
    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    px_stage_t           r_s1;
    logic                r_plot;
    logic [X_W-1:0]      r_x_out;
    logic [Y_W-1:0]      r_y_out;
    logic [COLOUR_W-1:0] r_colour;

    logic                w_clear;
    logic                w_advance;
    logic                w_last;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   w_col;
    logic [ADDR_W-1:0]   w_row;
    logic [X_W:0]        w_x_sum;
    logic [Y_W:0]        w_y_sum;
    logic                w_inb;
    logic                w_opaque;
    logic                w_pix_plot;

    assign w_clear   = (r_state == ST_IDLE) && start;
    assign w_advance = (r_state == ST_FETCH) && !w_last;

    sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_addr    (w_addr),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 1'b0;
            r_done      <= 1'b0;
            r_x0        <= '0;
            r_y0        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x0    <= x0;
                        r_y0    <= y0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_last) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= 1'b0;
                    end
                end
                // Two drain cycles let the last fetched word clear both pipeline stages.
                ST_DRAIN: begin
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Coordinates far beyond the 9/8-bit sums are clipped via the upper counter bits.
    assign w_x_sum = {1'b0, r_x0} + w_col[X_W:0];
    assign w_y_sum = {1'b0, r_y0} + w_row[Y_W:0];
    assign w_inb   = in_bounds(w_x_sum, w_y_sum) && !(|w_col[ADDR_W-1:X_W+1])
                     && !(|w_row[ADDR_W-1:Y_W+1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= (r_state == ST_FETCH);
            r_s1.inb   <= w_inb;
            r_s1.x     <= w_x_sum[X_W-1:0];
            r_s1.y     <= w_y_sum[Y_W-1:0];
        end
    end

`ifdef SPRITE_TRANSPARENCY_EN
    assign w_opaque = rd_data[0];
`else
    logic w_unused_opaque;
    assign w_unused_opaque = rd_data[0];
    assign w_opaque        = 1'b1;
`endif

    assign w_pix_plot = r_s1.valid && r_s1.inb && w_opaque;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plot   <= 1'b0;
            r_x_out  <= '0;
            r_y_out  <= '0;
            r_colour <= '0;
        end else begin
            r_plot <= w_pix_plot;
            if (w_pix_plot) begin
                r_x_out  <= r_s1.x;
                r_y_out  <= r_s1.y;
                r_colour <= rd_data[15:1];
            end
        end
    end

    assign rd_addr = w_addr;
    assign plot    = r_plot;
    assign x_out   = r_x_out;
    assign y_out   = r_y_out;
    assign colour  = r_colour;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_sprite_drawer.sv
// Bench for sprite_drawer: directed and randomized draws checked cycle by cycle
// against a pixel-index reference model (x = x0 + i%W, y = y0 + i/W, clipped).
module tb_sprite_drawer;

    localparam int W = 28;
    localparam int H = 30;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  x0;
    logic [6:0]  y0;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data;
    logic        plot;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [14:0] colour;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    int last_x, last_y, last_c;
    int st_plots, st_exp_plots, st_maxx;
    int fx, fy, fc, lx, ly, lc;

    sprite_drawer #(.SPRITE_W(W), .SPRITE_H(H)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .x0      (x0),
        .y0      (y0),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .plot    (plot),
        .x_out   (x_out),
        .y_out   (y_out),
        .colour  (colour),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_plot(input int i, input int bx, input int by);
        int  ex, ey;
        bit  inb;
        ex  = bx + (i % W);
        ey  = by + (i / W);
        inb = (ex <= 159) && (ey <= 119);
`ifdef SPRITE_TRANSPARENCY_EN
        return inb && mem[i][0];
`else
        return inb;
`endif
    endfunction

    task automatic run_draw(input string tag, input int bx, input int by,
                            input int second_k, input int abort_k,
                            input bit chain, input int nx, input int ny, input bit pre);
        int busy_err, done_err, pix_err, dones, plots, exp_plots, maxx, i, aborted_err;
        bit ep, first;
        busy_err = 0; done_err = 0; pix_err = 0; dones = 0; plots = 0;
        exp_plots = 0; maxx = 0; first = 1'b1; aborted_err = 0;
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
            x0    = 8'(bx);
            y0    = 7'(by);
        end
        for (int k = 1; k <= N + 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            x0    = 8'($urandom_range(0, 159));
            y0    = 7'($urandom_range(0, 119));
            i     = k - 3;
            ep    = (k >= 3 && k <= N + 2) ? model_plot(i, bx, by) : 1'b0;
            exp_plots += int'(ep);
            if (busy !== (k <= N + 2)) busy_err++;
            if (done !== (k == N + 3)) done_err++;
            if (done === 1'b1) dones++;
            if (plot !== ep) pix_err++;
            if (ep) begin
                last_x = bx + (i % W);
                last_y = by + (i / W);
                last_c = int'(mem[i][15:1]);
            end
            if (ep || k == N + 3) begin
                if (int'(x_out) != last_x || int'(y_out) != last_y || int'(colour) != last_c)
                    pix_err++;
            end
            if (plot === 1'b1) begin
                plots++;
                if (first) begin
                    fx = int'(x_out); fy = int'(y_out); fc = int'(colour);
                    first = 1'b0;
                end
                lx = int'(x_out); ly = int'(y_out); lc = int'(colour);
                if (int'(x_out) > maxx) maxx = int'(x_out);
            end
            if (k == second_k) begin
                start = 1'b1;
                x0    = 8'd0;
            end
            if (k == abort_k) begin
                reset = 1'b1;
                #1;
                check({tag, ".abort_plot"}, plot, 0);
                check({tag, ".abort_busy"}, busy, 0);
                check({tag, ".abort_done"}, done, 0);
                check({tag, ".abort_addr"}, rd_addr, 0);
                @(negedge clk);
                reset  = 1'b0;
                last_x = 0; last_y = 0; last_c = 0;
                for (int j = 0; j < 12; j++) begin
                    @(negedge clk);
                    if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) aborted_err++;
                end
                check({tag, ".after_abort_quiet"}, aborted_err, 0);
                check({tag, ".pre_abort_pixels"}, pix_err, 0);
                return;
            end
            if (k == N + 3 && chain) begin
                start = 1'b1;
                x0    = 8'(nx);
                y0    = 7'(ny);
            end
        end
        check({tag, ".busy_trace"}, busy_err, 0);
        check({tag, ".done_trace"}, done_err, 0);
        check({tag, ".pixel_trace"}, pix_err, 0);
        check({tag, ".done_count"}, dones, 1);
        check({tag, ".plot_count"}, plots, exp_plots);
        st_plots     = plots;
        st_exp_plots = exp_plots;
        st_maxx      = maxx;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        x0     = 8'd0;
        y0     = 7'd0;
        last_x = 0; last_y = 0; last_c = 0;
        for (int i = 0; i < 1024; i++) mem[i] = {i[14:0], 1'b1};

        repeat (3) @(negedge clk);
        check("rst.rd_addr", rd_addr, 0);
        check("rst.plot", plot, 0);
        check("rst.x_out", x_out, 0);
        check("rst.y_out", y_out, 0);
        check("rst.colour", colour, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Incrementing colour sprite fully on screen.
        run_draw("basic", 10, 20, 0, 0, 1'b0, 0, 0, 1'b0);
        check("basic.plots", st_plots, 840);
        check("basic.first_x", fx, 10);
        check("basic.first_y", fy, 20);
        check("basic.first_c", fc, 0);
        check("basic.last_x", lx, 37);
        check("basic.last_y", ly, 49);
        check("basic.last_c", lc, 839);

        // Bottom-right corner: clipped to a 10 x 20 block.
        run_draw("clip", 150, 100, 0, 0, 1'b0, 0, 0, 1'b0);
        check("clip.plots", st_plots, 200);
        check("clip.maxx_le_159", (st_maxx <= 159), 1);

        // Even words transparent.
        for (int i = 0; i < 1024; i++) mem[i] = {i[14:0], i[0]};
        run_draw("transp", 30, 40, 0, 0, 1'b0, 0, 0, 1'b0);
`ifdef SPRITE_TRANSPARENCY_EN
        check("transp.plots", st_plots, 420);
`else
        check("transp.plots", st_plots, 840);
`endif

        // Restart attempt mid-draw with a different origin.
        for (int i = 0; i < 1024; i++) mem[i] = {i[14:0], 1'b1};
        run_draw("restart", 40, 30, 100, 0, 1'b0, 0, 0, 1'b0);

        // Reset mid-draw, then a clean full draw.
        run_draw("abort", 5, 5, 0, 300, 1'b0, 0, 0, 1'b0);
        run_draw("post_abort", 5, 5, 0, 0, 1'b0, 0, 0, 1'b0);
        check("post_abort.plots", st_plots, 840);

        // Start coincident with done.
        run_draw("chain_a", 20, 10, 0, 0, 1'b1, 60, 50, 1'b0);
        run_draw("chain_b", 60, 50, 0, 0, 1'b0, 0, 0, 1'b1);
        check("chain_b.plots", st_plots, 840);

        // Random origins and random sprite contents.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
            run_draw($sformatf("rand%0d", r), int'($urandom_range(0, 159)),
                     int'($urandom_range(0, 119)), 0, 0, 1'b0, 0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sprite_drawer.md
SPRITE_DRAWER -- requirements
Module: sprite_drawer

Interface
REQ-001 Parameters SHALL be: SPRITE_W, default 28, sprite width in pixels; SPRITE_H, default 30, sprite height in rows; SPRITE_W*SPRITE_H SHALL be at most 1024.
REQ-002 Ports, clock and reset first:
  clk      in   1   system clock (CLOCK_50), rising edge.
  reset    in   1   asynchronous, active-high reset.
  start    in   1   draw request, single-cycle pulse.
  x0       in   8   sprite top-left column, 0..159.
  y0       in   7   sprite top-left row, 0..119.
  rd_addr  out  10  sprite memory word address.
  rd_data  in   16  sprite memory word; valid one cycle after rd_addr; bit 0 = opaque flag; bits 15:1 = colour.
  plot     out  1   pixel write strobe to frame buffer.
  x_out    out  8   pixel column.
  y_out    out  7   pixel row.
  colour   out  15  pixel colour, equal to rd_data[15:1].
  busy     out  1   draw in progress.
  done     out  1   one-cycle completion pulse.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
REQ-005 In IDLE, start=1 SHALL latch x0 and y0, set rd_addr=0, col=0 and row=0, and enter FETCH on the next edge.
REQ-006 In FETCH, each cycle SHALL present one address, advancing rd_addr, col and row in raster order: col wraps to 0 at SPRITE_W-1 and row increments.
REQ-007 After the address SPRITE_W*SPRITE_H-1 is presented, the FSM SHALL enter DRAIN; DRAIN SHALL last two cycles and then return to IDLE.
REQ-008 rd_addr = row*SPRITE_W + col SHALL hold at all times during a draw.
REQ-009 If rd_addr is presented at cycle t, then plot, x_out, y_out and colour for that pixel SHALL be registered and valid at cycle t+2.
REQ-010 Pixel coordinates SHALL be x_out = x0+col and y_out = y0+row.
REQ-011 Coordinate sums SHALL be formed one bit wider than the output: 9 bits for x and 8 bits for y.
REQ-012 plot SHALL be forced to 0 when the x sum exceeds 159 or the y sum exceeds 119; the pixel is clipped, not wrapped.
REQ-013 With start accepted at cycle S, busy SHALL be 1 from S+1 through S+SPRITE_W*SPRITE_H+2.
REQ-014 done SHALL pulse 1 at cycle S+SPRITE_W*SPRITE_H+3, and busy SHALL be 0 in that cycle.
REQ-015 start while busy=1 SHALL be ignored, and latched coordinates SHALL not change.
REQ-016 start in the same cycle as done SHALL be accepted.
REQ-017 Changes on x0 or y0 during a draw SHALL have no effect.
REQ-018 While not drawing, plot SHALL be 0, and x_out, y_out and colour SHALL hold their last values.

Reset
REQ-019 Reset SHALL set state=IDLE, rd_addr=0, plot=0, x_out=0, y_out=0, colour=0, busy=0 and done=0.
REQ-020 Reset during a draw SHALL abort the draw immediately; no done pulse SHALL follow, and no plot SHALL occur until a new start is accepted.

Configuration
REQ-021 With SPRITE_TRANSPARENCY_EN defined, plot SHALL additionally be gated by rd_data[0]; a word with bit 0 = 0 produces no plot.
REQ-022 Without SPRITE_TRANSPARENCY_EN, every in-bounds pixel SHALL be plotted regardless of bit 0.
REQ-023 Pipeline timing and the done pulse SHALL be identical with and without SPRITE_TRANSPARENCY_EN.

Structure
REQ-024 The shared package SHALL hold FSM state encodings, the screen limits (160, 120), the address width (10) and the colour width (15).
REQ-025 One sub-module, sprite_addr_gen, SHALL hold the col/row/address raster counter with wrap and last-pixel flag.
REQ-026 The top level SHALL hold the FSM, the two-stage output pipeline and clipping.

Verification
REQ-027 Bench: start with x0=10, y0=20, memory word i = {i[14:0],1} -> 840 plots; first is (10,20) with colour 0; last is (37,49) with colour 839; done exactly once at S+843.
REQ-028 Bench: x0=150, y0=100, all words opaque -> only col<=9 and row<=19 plotted (200 plots); no x_out above 159; done timing unchanged.
REQ-029 Bench: SPRITE_TRANSPARENCY_EN defined, even addresses with bit 0 = 0 -> exactly 420 plots, all at odd addresses; undefined -> 840 plots.
REQ-030 Bench: second start at S+100 with x0=0 -> ignored; all plots keep the original x0; single done.
REQ-031 Bench: reset asserted at S+300 -> plot, busy and done go to 0 at once; no done pulse; a fresh start then completes a full 840-pixel draw.
REQ-032 Bench: start asserted in the same cycle as done -> back-to-back draws; busy low for exactly that one cycle.
